// File: rtl/io_mapped_data_memory_if.sv
// CPU and monitor bus bundle for io_mapped_data_memory.
// The master side is the CPU/monitor; the slave side is the memory block.
interface io_mapped_data_memory_if;
    logic        prg_mode;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        prg_we;
    logic [31:0] prg_addr;
    logic [31:0] prg_wd;
    logic [31:0] prg_rd;

    modport master (
        output prg_mode, we, addr, wd, prg_we, prg_addr, prg_wd,
        input  rd, prg_rd
    );

    modport slave (
        input  prg_mode, we, addr, wd, prg_we, prg_addr, prg_wd,
        output rd, prg_rd
    );
endinterface

// File: rtl/io_mapped_data_memory.sv
// Data RAM shared between CPU and monitor, with an IO window of output ports,
// synchronized input ports, sticky rising-edge flags and a level interrupt.
module io_mapped_data_memory #(
    parameter int          RAM_AW  = 11,
    parameter int          N_OUT   = 4,
    parameter int          N_IN    = 4,
    parameter logic [23:0] IO_BASE = 24'hFFFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    io_mapped_data_memory_if.slave bus,
    output logic [32*N_OUT-1:0]   oport,
    input  logic [32*N_IN-1:0]    iport,
    output logic                  irq
);
    localparam int DEPTH = 2 ** RAM_AW;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       out_q [N_OUT];
    logic [31:0]       s1 [N_IN];
    logic [31:0]       s2 [N_IN];
    logic [31:0]       prev [N_IN];
    logic [31:0]       flag [N_IN];
    logic [31:0]       clr_mask [N_IN];
    logic [N_IN-1:0]   irq_en;

    logic              io_sel;
    logic [2:0]        grp;
    logic [2:0]        idx;
    logic [RAM_AW-1:0] cpu_word;
    logic [RAM_AW-1:0] prg_word;
    logic              cpu_io_wr;
    logic [31:0]       rd_io;

    assign io_sel    = (bus.addr[31:8] == IO_BASE);
    assign grp       = bus.addr[7:5];
    assign idx       = bus.addr[4:2];
    assign cpu_word  = bus.addr[RAM_AW+1:2];
    assign prg_word  = bus.prg_addr[RAM_AW+1:2];
    assign cpu_io_wr = !bus.prg_mode && bus.we && io_sel;

    // prg_mode picks the single RAM owner, so the two write ports never collide
    always_ff @(posedge clk) begin
        if (bus.prg_mode) begin
            if (bus.prg_we)
                mem[prg_word] <= bus.prg_wd;
        end else if (bus.we && !io_sel) begin
            mem[cpu_word] <= bus.wd;
        end
    end

    // Output port registers; an index beyond N_OUT matches no register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_OUT; i++)
                out_q[i] <= '0;
        end else if (cpu_io_wr) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (idx == 3'(i)) begin
                    case (grp)
                        3'd0:    out_q[i] <= bus.wd;
                        3'd1:    out_q[i] <= out_q[i] | bus.wd;
                        3'd2:    out_q[i] <= out_q[i] & ~bus.wd;
                        3'd3:    out_q[i] <= out_q[i] ^ bus.wd;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_IN; i++)
            clr_mask[i] = (cpu_io_wr && grp == 3'd5 && idx == 3'(i)) ? bus.wd : '0;
    end

    // Edge term is OR'd after the clear so a simultaneous new edge survives W1C
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_IN; i++) begin
                s1[i]   <= '0;
                s2[i]   <= '0;
                prev[i] <= '0;
                flag[i] <= '0;
            end
            irq_en <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                s1[i]   <= iport[32*i +: 32];
                s2[i]   <= s1[i];
                prev[i] <= s2[i];
                flag[i] <= (flag[i] & ~clr_mask[i]) | (s2[i] & ~prev[i]);
            end
            if (cpu_io_wr && grp == 3'd6)
                irq_en <= bus.wd[N_IN-1:0];
        end
    end

    always_comb begin
        rd_io = '0;
        case (grp)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                for (int i = 0; i < N_OUT; i++)
                    if (idx == 3'(i)) rd_io = out_q[i];
            end
            3'd4: begin
                for (int i = 0; i < N_IN; i++)
                    if (idx == 3'(i)) rd_io = s2[i];
            end
            3'd5: begin
                for (int i = 0; i < N_IN; i++)
                    if (idx == 3'(i)) rd_io = flag[i];
            end
            3'd6:    rd_io[N_IN-1:0] = irq_en;
            default: ;
        endcase
    end

    always_comb begin
        if (bus.prg_mode)
            bus.rd = '0;
        else if (io_sel)
            bus.rd = rd_io;
        else
            bus.rd = mem[cpu_word];
    end

    assign bus.prg_rd = mem[prg_word];

    always_comb begin
        irq = 1'b0;
        for (int i = 0; i < N_IN; i++)
            irq = irq | (irq_en[i] & (|flag[i]));
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_oport
        assign oport[32*g +: 32] = out_q[g];
    end
endmodule

// File: tb/tb_io_mapped_data_memory.sv
// Directed self-checking bench for io_mapped_data_memory (N_OUT=2, N_IN=4):
// a vector table for IO/RAM accesses plus sequences for sync, flags and reset.
module tb_io_mapped_data_memory;
    localparam int N_OUT = 2;
    localparam int N_IN  = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [32*N_OUT-1:0] oport;
    logic [32*N_IN-1:0]  iport;
    logic                irq;
    int                  n_cmp  = 0;
    int                  n_fail = 0;

    io_mapped_data_memory_if bus_if ();

    io_mapped_data_memory #(
        .RAM_AW (11),
        .N_OUT  (N_OUT),
        .N_IN   (N_IN),
        .IO_BASE(24'hFFFFFF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if),
        .oport(oport),
        .iport(iport),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [63:0] exp_oport;
    } vec_t;

    vec_t vecs [12];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write lands at the next posedge; we drops on the following negedge
    task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        bus_if.addr = addr;
        bus_if.wd   = wd;
        bus_if.we   = 1'b1;
        @(negedge clk);
        bus_if.we   = 1'b0;
        #1;
    endtask

    task automatic read_io(input logic [31:0] addr, output logic [31:0] data);
        bus_if.addr = addr;
        #1;
        data = bus_if.rd;
    endtask

    initial begin
        logic [31:0] d;

        vecs[0]  = '{"out1_write", 1'b1, 32'hFFFFFF04, 32'h0000FF00, 32'h0000FF00, {32'h0000FF00, 32'h0}};
        vecs[1]  = '{"out1_set",   1'b1, 32'hFFFFFF24, 32'h00000001, 32'h0000FF01, {32'h0000FF01, 32'h0}};
        vecs[2]  = '{"out1_clr",   1'b1, 32'hFFFFFF44, 32'h00000100, 32'h0000FE01, {32'h0000FE01, 32'h0}};
        vecs[3]  = '{"out1_tgl",   1'b1, 32'hFFFFFF64, 32'hF0000000, 32'hF000FE01, {32'hF000FE01, 32'h0}};
        vecs[4]  = '{"out1_rdset", 1'b0, 32'hFFFFFF24, 32'h0,        32'hF000FE01, {32'hF000FE01, 32'h0}};
        vecs[5]  = '{"out5_ign",   1'b1, 32'hFFFFFF14, 32'h0000AAAA, 32'h0,        {32'hF000FE01, 32'h0}};
        vecs[6]  = '{"out0_write", 1'b1, 32'hFFFFFF00, 32'h12345678, 32'h12345678, {32'hF000FE01, 32'h12345678}};
        vecs[7]  = '{"in0_ro",     1'b1, 32'hFFFFFF80, 32'h0000FFFF, 32'h0,        {32'hF000FE01, 32'h12345678}};
        vecs[8]  = '{"reserved",   1'b1, 32'hFFFFFFE0, 32'hFFFFFFFF, 32'h0,        {32'hF000FE01, 32'h12345678}};
        vecs[9]  = '{"irq_en",     1'b1, 32'hFFFFFFC0, 32'h00000004, 32'h00000004, {32'hF000FE01, 32'h12345678}};
        vecs[10] = '{"ram_write",  1'b1, 32'h00000020, 32'h00001234, 32'h00001234, {32'hF000FE01, 32'h12345678}};
        vecs[11] = '{"ram_alias",  1'b0, 32'h00004020, 32'h0,        32'h00001234, {32'hF000FE01, 32'h12345678}};

        reset           = 1'b1;
        iport           = '0;
        bus_if.prg_mode = 1'b0;
        bus_if.we       = 1'b0;
        bus_if.addr     = '0;
        bus_if.wd       = '0;
        bus_if.prg_we   = 1'b0;
        bus_if.prg_addr = '0;
        bus_if.prg_wd   = '0;

        repeat (2) @(posedge clk);
        #1;
        check_output("reset_oport", oport, 64'h0);
        check_output("reset_irq", {63'h0, irq}, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Monitor load, then CPU sees the same word in run mode
        @(negedge clk);
        bus_if.prg_mode = 1'b1;
        bus_if.prg_we   = 1'b1;
        bus_if.prg_addr = 32'h00000010;
        bus_if.prg_wd   = 32'hDEADBEEF;
        bus_if.addr     = 32'h00000010;
        @(negedge clk);
        bus_if.prg_we = 1'b0;
        #1;
        check_output("prg_rd_load", {32'h0, bus_if.prg_rd}, {32'h0, 32'hDEADBEEF});
        check_output("rd_in_prg",   {32'h0, bus_if.rd},     64'h0);
        bus_if.prg_mode = 1'b0;
        #1;
        check_output("cpu_rd_ram",  {32'h0, bus_if.rd},     {32'h0, 32'hDEADBEEF});

        @(negedge clk);
        bus_if.prg_we = 1'b1;
        bus_if.prg_wd = 32'h0BADF00D;
        @(negedge clk);
        bus_if.prg_we = 1'b0;
        #1;
        check_output("prg_we_ign",  {32'h0, bus_if.prg_rd}, {32'h0, 32'hDEADBEEF});

        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            bus_if.addr = vecs[k].addr;
            bus_if.wd   = vecs[k].wd;
            bus_if.we   = vecs[k].we;
            if (vecs[k].we) begin
                @(negedge clk);
                bus_if.we = 1'b0;
            end
            #1;
            check_output({vecs[k].name, "_rd"}, {32'h0, bus_if.rd}, {32'h0, vecs[k].exp_rd});
            check_output({vecs[k].name, "_oport"}, oport, vecs[k].exp_oport);
        end

        // CPU writes while the monitor owns the RAM must have no effect
        bus_if.prg_mode = 1'b1;
        bus_if.prg_addr = 32'h00000020;
        apply_stimulus(32'h00000020, 32'h00005555);
        apply_stimulus(32'hFFFFFF00, 32'h0);
        check_output("prg_cpu_rd0", {32'h0, bus_if.rd}, 64'h0);
        check_output("prg_cpu_ram", {32'h0, bus_if.prg_rd}, {32'h0, 32'h00001234});
        check_output("prg_cpu_out", oport, {32'hF000FE01, 32'h12345678});
        bus_if.prg_mode = 1'b0;

        // Synchronizer and flag latency for iport2 bit3
        @(negedge clk);
        iport[67] = 1'b1;
        @(posedge clk); #1;
        read_io(32'hFFFFFF88, d);
        check_output("in2_k", {32'h0, d}, 64'h0);
        @(posedge clk); #1;
        read_io(32'hFFFFFF88, d);
        check_output("in2_k1", {32'h0, d}, 64'h8);
        read_io(32'hFFFFFFA8, d);
        check_output("flag2_k1", {32'h0, d}, 64'h0);
        @(posedge clk); #1;
        read_io(32'hFFFFFFA8, d);
        check_output("flag2_k2", {32'h0, d}, 64'h8);
        check_output("irq_set", {63'h0, irq}, 64'h1);

        // W1C colliding with a fresh edge: the edge must win
        @(negedge clk);
        iport[67] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        iport[67] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        apply_stimulus(32'hFFFFFFA8, 32'h8);
        read_io(32'hFFFFFFA8, d);
        check_output("w1c_collide", {32'h0, d}, 64'h8);
        apply_stimulus(32'hFFFFFFA8, 32'h8);
        read_io(32'hFFFFFFA8, d);
        check_output("w1c_clear", {32'h0, d}, 64'h0);
        check_output("irq_clear", {63'h0, irq}, 64'h0);

        // Re-arm the flag, then reset during an OUT_0 write
        @(negedge clk);
        iport[67] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        iport[67] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_output("irq_rearm", {63'h0, irq}, 64'h1);
        @(negedge clk);
        bus_if.addr = 32'hFFFFFF00;
        bus_if.wd   = 32'hFFFFFFFF;
        bus_if.we   = 1'b1;
        reset       = 1'b1;
        #1;
        check_output("rst_oport", oport, 64'h0);
        check_output("rst_irq", {63'h0, irq}, 64'h0);
        @(negedge clk);
        bus_if.we = 1'b0;
        reset     = 1'b0;
        #1;
        check_output("rst_discard", oport, 64'h0);
        bus_if.addr = 32'h00000010;
        #1;
        check_output("rst_ram", {32'h0, bus_if.rd}, {32'h0, 32'hDEADBEEF});

        // iport2 bit3 held high across release counts as an edge
        @(posedge clk);
        @(posedge clk); #1;
        read_io(32'hFFFFFFA8, d);
        check_output("rel_flag_e2", {32'h0, d}, 64'h0);
        @(posedge clk); #1;
        read_io(32'hFFFFFFA8, d);
        check_output("rel_flag_e3", {32'h0, d}, 64'h8);
        check_output("rel_irq_en0", {63'h0, irq}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/io_mapped_data_memory.md
IO_MAPPED_DATA_MEMORY -- requirements
Module: io_mapped_data_memory

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- RAM_AW, 11: RAM word-address width; depth 2**RAM_AW words.
- N_OUT, 4: output port count, 1..8.
- N_IN, 4: input port count, 1..8.
- IO_BASE, 24'hFFFFFF: addr[31:8] value that selects IO space.

REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk, in, 1: single clock, rising edge; reset is asynchronous and active-high.
- reset, in, 1: asynchronous, active-high.
- prg_mode, in, 1: 1 = monitor owns RAM, 0 = CPU run mode.
- we, in, 1: CPU write enable.
- addr, in, 32: CPU byte address.
- wd, in, 32: CPU write data.
- rd, out, 32: CPU read data.
- prg_we, in, 1: monitor write enable.
- prg_addr, in, 32: monitor byte address.
- prg_wd, in, 32: monitor write data.
- prg_rd, out, 32: monitor read data.
- oport, out, 32*N_OUT: output ports; port i occupies bits [32i+31:32i].
- iport, in, 32*N_IN: asynchronous input ports, same packing as oport.
- irq, out, 1: level interrupt request.

Function
REQ-003 The block SHALL decode io_sel = (addr[31:8]==IO_BASE); when io_sel=0 the access SHALL target RAM word addr[RAM_AW+1:2], ignoring the higher bits.
REQ-004 IO offsets SHALL use addr[7:5] for the group and addr[4:2] for index i:
- 0: OUT_i, read/write.
- 1: OUT_i SET, oport_i |= wd.
- 2: OUT_i CLR, oport_i &= ~wd.
- 3: OUT_i TGL, oport_i ^= wd.
- 4: IN_i, read-only synchronized value.
- 5: FLAG_i, rising-edge sticky flags, write-1-to-clear.
- 6: IRQ_EN, bits [N_IN-1:0], read/write; i ignored.
- 7: reserved.
REQ-005 Reads of groups 1–3 SHALL return OUT_i.
REQ-006 Writes to read-only or reserved locations, and any access with i>=N_OUT (groups 0–3) or i>=N_IN (groups 4–5), SHALL be ignored and SHALL read 0.
REQ-007 rd and prg_rd SHALL be combinational (zero-latency) functions of the current address and state; all writes SHALL take effect at the next rising clk.
REQ-008 When prg_mode=1, CPU writes to RAM and IO SHALL be suppressed and rd SHALL be 0; prg_we SHALL write RAM word prg_addr[RAM_AW+1:2].
REQ-009 When prg_mode=0, prg_we SHALL be ignored.
REQ-010 prg_rd SHALL always return the RAM word at prg_addr, regardless of prg_mode.
REQ-011 Each input port SHALL pass through two synchronizer flops (s1, s2) plus a history flop (prev).
REQ-012 IN_i SHALL read s2.
REQ-013 Per-bit edge = s2 & ~prev; FLAG_i SHALL update each cycle as (FLAG_i & ~clr_mask) | edge.
REQ-014 When a new edge and a W1C hit the same bit in the same cycle, the new edge SHALL win and the bit SHALL stay set.
REQ-015 Latency: an iport bit rising before edge k SHALL appear in IN_i after edge k+1 and in FLAG_i after edge k+2.
REQ-016 irq SHALL equal the OR over i<N_IN of (IRQ_EN[i] & |FLAG_i), combinationally.
REQ-017 RAM SHALL be a single array with one write port per owner, never both active in the same cycle (guaranteed by REQ-008/REQ-009).

Reset
REQ-018 While reset=1, oport, IRQ_EN, all s1/s2/prev flops, and all FLAG_i SHALL be 0, so irq=0.
REQ-019 RAM contents SHALL NOT be affected by reset.
REQ-020 An iport bit held high across reset release SHALL be treated as a rising edge and set its flag 3 cycles after release.
REQ-021 Reset asserted mid-write SHALL discard that write for IO registers; the RAM write outcome for that cycle is unspecified.

Verification
REQ-022 Bench SHALL cover these scenarios:
- prg_mode=1, prg write 0xDEADBEEF to 0x00000010 -> prg_rd=0xDEADBEEF and rd=0; prg_mode=0, CPU reads 0x10 -> rd=0xDEADBEEF.
- CPU writes OUT_1=0x0000FF00, SET 0x1, CLR 0x100, TGL 0xF0000000 -> oport1=0xF000FE01; reading SET address returns the same value.
- iport2 bit3 rises before edge k -> IN_2 bit3=1 after k+1, FLAG_2=0x8 after k+2; with IRQ_EN=0x4, irq=1.
- W1C FLAG_2=0x8 in the same cycle as a new edge on bit3 -> flag stays 0x8; a later W1C with no edge -> 0x0 and irq=0.
- N_OUT=2: write OUT_5 -> ignored, reads 0; a CPU write while prg_mode=1 -> RAM and oport unchanged.
- Assert reset mid-run with oport0=0x12345678 and flags set -> oport0=0, irq=0 immediately; RAM word retains its value.
